// File: rtl/gpu_warp_scheduler.sv
// Per-warp thread scheduler: tracks thread state, resume PC and barrier id, picks a
// PC group of READY threads each round, and applies the executed instruction's outcome.
module gpu_warp_scheduler #(
    parameter int NUM_THREADS = 8,
    parameter int PC_W        = 4,
    parameter int BAR_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PC_W-1:0]        start_pc,
    input  logic [NUM_THREADS-1:0] launch_mask,
    output logic                   busy,
    output logic                   done,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [PC_W-1:0]        issue_pc,
    output logic [NUM_THREADS-1:0] issue_mask,
    input  logic                   result_valid,
    input  logic                   res_exit,
    input  logic                   res_bar,
    input  logic [BAR_W-1:0]       res_bar_id,
    input  logic                   res_yield,
    input  logic                   branch_happening,
    input  logic [NUM_THREADS-1:0] branch_taken,
    input  logic [PC_W-1:0]        branch_target,
    output logic                   diverged
);
    localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {T_EXITED, T_READY, T_BLOCKED, T_YIELDED} tstate_t;

    state_t           r_state, w_next_state;
    tstate_t          r_tstate [NUM_THREADS];
    logic [PC_W-1:0]  r_pc     [NUM_THREADS];
    logic [BAR_W-1:0] r_bar    [NUM_THREADS];
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PC_W-1:0]  r_issue_pc;
    logic [NUM_THREADS-1:0] r_issue_mask;

    logic [NUM_THREADS-1:0] w_ready_vec, w_yield_vec, w_block_vec;
    logic [NUM_THREADS-1:0] w_sel_mask, w_release_mask, w_taken_set, w_fall_set;
    logic [PTR_W-1:0] w_leader, w_top_bit, w_rr_next;
    logic             w_lead_found;
    logic [BAR_W-1:0] w_min_bar;
    logic [PC_W-1:0]  w_pc_plus1;
    logic             w_result, w_transfer, w_launch, w_branch_only;

    // Per-thread classification, round-robin leader pick and barrier release group.
    always_comb begin
        w_ready_vec  = '0;
        w_yield_vec  = '0;
        w_block_vec  = '0;
        w_sel_mask   = '0;
        w_release_mask = '0;
        w_lead_found = 1'b0;
        w_leader     = '0;
        w_min_bar    = '1;
        w_top_bit    = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_ready_vec[i] = (r_tstate[i] == T_READY);
            w_yield_vec[i] = (r_tstate[i] == T_YIELDED);
            w_block_vec[i] = (r_tstate[i] == T_BLOCKED);
            if (w_block_vec[i] && r_bar[i] <= w_min_bar) w_min_bar = r_bar[i];
            if (r_issue_mask[i]) w_top_bit = PTR_W'(i);
        end
        for (int k = 0; k < NUM_THREADS; k++) begin
            if (!w_lead_found && w_ready_vec[(int'(r_rr_ptr) + k) % NUM_THREADS]) begin
                w_lead_found = 1'b1;
                w_leader     = PTR_W'((int'(r_rr_ptr) + k) % NUM_THREADS);
            end
        end
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_sel_mask[i]     = w_ready_vec[i] && (r_pc[i] == r_pc[w_leader]);
            w_release_mask[i] = w_block_vec[i] && (r_bar[i] == w_min_bar);
        end
    end

    assign w_rr_next     = (int'(w_top_bit) == NUM_THREADS - 1) ? '0 : w_top_bit + 1'b1;
    assign w_pc_plus1    = r_issue_pc + 1'b1;
    assign w_result      = (r_state == S_WAIT) && result_valid;
    assign w_transfer    = (r_state == S_ISSUE) && issue_ready;
    assign w_launch      = (r_state == S_IDLE) && start;
    assign w_branch_only = !res_exit && !res_bar && !res_yield && branch_happening;
    assign w_taken_set   = branch_taken & r_issue_mask;
    assign w_fall_set    = ~branch_taken & r_issue_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start && |launch_mask) w_next_state = S_SELECT;
            S_SELECT: if (|w_ready_vec)                      w_next_state = S_ISSUE;
                      else if (!(|w_yield_vec) && !(|w_block_vec)) w_next_state = S_IDLE;
            S_ISSUE:  if (issue_ready)  w_next_state = S_WAIT;
            S_WAIT:   if (result_valid) w_next_state = S_SELECT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        issue_valid = (r_state == S_ISSUE);
        done        = (w_launch && !(|launch_mask)) ||
                      ((r_state == S_SELECT) && !(|w_ready_vec) && !(|w_yield_vec) && !(|w_block_vec));
        diverged    = w_result && w_branch_only && (|w_taken_set) && (|w_fall_set);
    end

    // NOTE: the per-thread arrays are a handful of flops, not a RAM, so they take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_tstate[i] <= T_EXITED;
                r_pc[i]     <= '0;
                r_bar[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (w_launch) begin
                    r_tstate[i] <= launch_mask[i] ? T_READY : T_EXITED;
                    if (launch_mask[i]) r_pc[i] <= start_pc;
                end else if (r_state == S_SELECT && !(|w_ready_vec)) begin
                    if (|w_yield_vec) begin
                        if (w_yield_vec[i]) r_tstate[i] <= T_READY;
                    end else if (w_release_mask[i]) begin
                        r_tstate[i] <= T_READY;
                    end
                end else if (w_result && r_issue_mask[i]) begin
                    if (res_exit) begin
                        r_tstate[i] <= T_EXITED;
                    end else if (res_bar) begin
                        r_tstate[i] <= T_BLOCKED;
                        r_bar[i]    <= res_bar_id;
                        r_pc[i]     <= w_pc_plus1;
                    end else if (res_yield) begin
                        r_tstate[i] <= T_YIELDED;
                        r_pc[i]     <= w_pc_plus1;
                    end else if (branch_happening && branch_taken[i]) begin
                        r_pc[i]     <= branch_target;
                    end else begin
                        r_pc[i]     <= w_pc_plus1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_issue_pc   <= '0;
            r_issue_mask <= '0;
        end else begin
            if (r_state == S_SELECT && w_lead_found) begin
                r_issue_pc   <= r_pc[w_leader];
                r_issue_mask <= w_sel_mask;
            end
            if (w_transfer) r_rr_ptr <= w_rr_next;
        end
    end

    assign issue_pc   = r_issue_pc;
    assign issue_mask = r_issue_mask;
endmodule
